// File: rtl/subframe_sequencer.sv
// Frame-level controller: runs one subframe decoder once per FLAC channel, relocating its
// read addresses and tagging its samples. Optional stall watchdog: SUBFRAME_SEQ_WATCHDOG_EN.
module subframe_sequencer #(
  parameter int MAX_CH      = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [15:0] iBlockSize,
  input  logic [2:0]  iChannels,
  input  logic [15:0] iFrameBase,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic        oDecReset,
  output logic        oDecEnable,
  output logic [15:0] oDecBlockSize,
  input  logic        iDecSampleValid,
  input  logic [15:0] iDecSample,
  input  logic [15:0] iDecReadAddr,
  output logic [15:0] oRamReadAddr,
  output logic        oSampleValid,
  output logic [15:0] oSample,
  output logic [2:0]  oSampleChannel,
  output logic [15:0] oSampleIndex
);

  // state  | meaning
  // IDLE   | waiting for iStart, decoder held in reset
  // DECRST | one-cycle decoder reset for the current channel
  // RUN    | decoder running, samples tagged and counted
  // NEXT   | move base past the finished subframe, pick next channel
  // FIN    | oDone pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECRST,
    S_RUN,
    S_NEXT,
    S_FIN
  } state_t;

  localparam logic [2:0] CH_LAST = 3'(MAX_CH - 1);

  state_t      state, state_nxt;
  logic [15:0] blk_q;
  logic [15:0] base_q;
  logic [15:0] maxaddr_q;
  logic [15:0] count_q;
  logic [2:0]  nch_q;
  logic [2:0]  ch_q;
  logic        accept;
  logic        last_sample;
  logic        wdog_expire;

  assign accept      = (state == S_RUN) && iDecSampleValid;
  assign last_sample = accept && (count_q == blk_q);

`ifdef SUBFRAME_SEQ_WATCHDOG_EN
  logic [15:0] stall_q;
  logic        err_q;

  // a strobe in the expiry cycle keeps the channel alive
  assign wdog_expire = (state == S_RUN) && !iDecSampleValid &&
                       (stall_q == 16'(WDOG_CYCLES - 1));

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      stall_q <= 16'd0;
    end else if ((state != S_RUN) || iDecSampleValid) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_q + 16'd1;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE) && iStart) begin
      err_q <= 1'b0;
    end else if (wdog_expire) begin
      err_q <= 1'b1;
    end
  end

  assign oError = err_q | wdog_expire;
`else
  // no watchdog: expiry can never fire
  assign wdog_expire = 1'b0 && (WDOG_CYCLES != 0);
  assign oError      = 1'b0;
`endif

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    oBusy      = 1'b1;
    oDone      = 1'b0;
    oDecReset  = 1'b0;
    oDecEnable = 1'b0;
    case (state)
      S_IDLE: begin
        oBusy     = 1'b0;
        oDecReset = 1'b1;
        if (iStart) state_nxt = S_DECRST;
      end
      S_DECRST: begin
        oDecReset = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        oDecEnable = !wdog_expire;
        if (last_sample) begin
          state_nxt = S_NEXT;
        end else if (wdog_expire) begin
          state_nxt = S_FIN;
        end
      end
      S_NEXT: begin
        state_nxt = (ch_q == nch_q) ? S_FIN : S_DECRST;
      end
      S_FIN: begin
        oDone     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      blk_q     <= 16'd0;
      nch_q     <= 3'd0;
      base_q    <= 16'd0;
      ch_q      <= 3'd0;
      count_q   <= 16'd0;
      maxaddr_q <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart) begin
            blk_q     <= iBlockSize;
            nch_q     <= (iChannels > CH_LAST) ? CH_LAST : iChannels;
            base_q    <= iFrameBase;
            ch_q      <= 3'd0;
            count_q   <= 16'd0;
            maxaddr_q <= 16'd0;
          end
        end
        S_RUN: begin
          if (iDecReadAddr > maxaddr_q) maxaddr_q <= iDecReadAddr;
          if (accept) count_q <= count_q + 16'd1;
        end
        S_NEXT: begin
          // the next subframe starts right after the highest word this one touched
          base_q    <= base_q + maxaddr_q + 16'd1;
          maxaddr_q <= 16'd0;
          count_q   <= 16'd0;
          if (ch_q != nch_q) ch_q <= ch_q + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      oSampleValid   <= 1'b0;
      oSample        <= 16'd0;
      oSampleChannel <= 3'd0;
      oSampleIndex   <= 16'd0;
    end else begin
      oSampleValid <= accept;
      if (accept) begin
        oSample        <= iDecSample;
        oSampleChannel <= ch_q;
        oSampleIndex   <= count_q;
      end
    end
  end

  assign oDecBlockSize = blk_q;
  assign oRamReadAddr  = base_q + iDecReadAddr;

endmodule

// File: tb/tb_subframe_sequencer.sv
// Bench for subframe_sequencer: directed frames, a per-cycle reference of phase, base
// and tagged samples, plus a few literal expectations on known frames.
module tb_subframe_sequencer;

  localparam int WDOG = 16;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iBlockSize = 16'd0;
  logic [2:0]  iChannels = 3'd0;
  logic [15:0] iFrameBase = 16'd0;
  logic        iDecSampleValid = 1'b0;
  logic [15:0] iDecSample = 16'd0;
  logic [15:0] iDecReadAddr = 16'd0;
  logic        oBusy, oDone, oError, oDecReset, oDecEnable, oSampleValid;
  logic [15:0] oDecBlockSize, oRamReadAddr, oSample, oSampleIndex;
  logic [2:0]  oSampleChannel;

  always #5 iClock = ~iClock;

  subframe_sequencer #(.MAX_CH(8), .WDOG_CYCLES(WDOG)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
    .iChannels(iChannels), .iFrameBase(iFrameBase), .oBusy(oBusy), .oDone(oDone),
    .oError(oError), .oDecReset(oDecReset), .oDecEnable(oDecEnable),
    .oDecBlockSize(oDecBlockSize), .iDecSampleValid(iDecSampleValid),
    .iDecSample(iDecSample), .iDecReadAddr(iDecReadAddr), .oRamReadAddr(oRamReadAddr),
    .oSampleValid(oSampleValid), .oSample(oSample), .oSampleChannel(oSampleChannel),
    .oSampleIndex(oSampleIndex)
  );

  // phase the controller must be in during the current cycle; P_EXP is a watchdog expiry cycle
  typedef enum int {P_IDLE, P_RST, P_RUN, P_NEXT, P_FIN, P_EXP} phase_t;

  phase_t      m_phase = P_IDLE;
  logic [15:0] m_base = 16'd0;
  logic [15:0] m_bs = 16'd0;
  logic        m_err = 1'b0;
  logic [2:0]  m_ch = 3'd0;
  logic [15:0] m_idx = 16'd0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] smp_of(input int c, input int i);
    return c[0] ? 16'(16'hFFFF - i) : 16'(i + 1);
  endfunction

  logic        pend_v = 1'b0;
  logic [15:0] pend_s = 16'd0;
  logic [15:0] pend_i = 16'd0;
  logic [2:0]  pend_c = 3'd0;

  always @(negedge iClock) begin
    if (!iReset) begin
      chk("rst_busy", oBusy, 0);
      chk("rst_done", oDone, 0);
      chk("rst_error", oError, 0);
      chk("rst_dec_reset", oDecReset, 1);
      chk("rst_dec_enable", oDecEnable, 0);
      chk("rst_blk", oDecBlockSize, 0);
      chk("rst_svalid", oSampleValid, 0);
      chk("rst_sample", {oSample, oSampleIndex}, 0);
      chk("rst_schan", oSampleChannel, 0);
      chk("rst_ram_addr", oRamReadAddr, iDecReadAddr);
      pend_v = 1'b0;
    end else begin
      chk("busy", oBusy, m_phase != P_IDLE);
      chk("done", oDone, m_phase == P_FIN);
      chk("dec_reset", oDecReset, m_phase inside {P_IDLE, P_RST});
      chk("dec_enable", oDecEnable, m_phase == P_RUN);
      chk("error", oError, m_err);
      chk("blk", oDecBlockSize, m_bs);
      chk("ram_addr", oRamReadAddr, 16'(m_base + iDecReadAddr));
      chk("svalid", oSampleValid, pend_v);
      if (pend_v) begin
        chk("sample", oSample, pend_s);
        chk("schan", oSampleChannel, pend_c);
        chk("sindex", oSampleIndex, pend_i);
      end
      pend_v = (m_phase == P_RUN) && iDecSampleValid;
      pend_s = iDecSample;
      pend_c = m_ch;
      pend_i = m_idx;
    end
  end

  task automatic cyc(input phase_t ph, input bit strb, input logic [15:0] smp,
                     input logic [15:0] addr, input bit start, input logic [2:0] ch,
                     input logic [15:0] idx);
    @(posedge iClock);
    #1;
    m_phase = ph;
    m_ch = ch;
    m_idx = idx;
    iDecSampleValid = strb;
    iDecSample = smp;
    iDecReadAddr = addr;
    iStart = start;
  endtask

  task automatic run_frame(input logic [15:0] base, input logic [15:0] bs, input logic [2:0] nch,
                           input int gap, input int pin, input bit poke, input bit abort);
    logic [15:0] a, chmax, prev_max;
    iBlockSize = bs;
    iChannels = nch;
    iFrameBase = base;
    cyc(P_IDLE, 0, 16'd0, 16'd0, 1, 3'd0, 16'd0);
    prev_max = 16'd0;
    for (int c = 0; c <= int'(nch); c++) begin
      cyc(P_RST, 0, 16'd0, 16'hFFFF, 0, 3'(c), 16'd0);
      if (c == 0) begin
        m_base = base;
        m_bs = bs;
        m_err = 1'b0;
      end else begin
        m_base = 16'(m_base + prev_max + 16'd1);
      end
      chmax = 16'd0;
      for (int i = 0; i <= int'(bs); i++) begin
        for (int g = 0; g <= gap; g++) begin
          a = 16'((i * 2 + g) % 10);
          if (a > chmax) chmax = a;
          cyc(P_RUN, g == gap, smp_of(c, i), a, poke && c == 0 && i == 1 && g == gap,
              3'(c), 16'(i));
          if (poke && c == 0 && i == 1 && g == gap) begin
            iFrameBase = 16'h5555;
            iBlockSize = 16'd9;
            iChannels = 3'd5;
          end
          if (pin == 1 && i == 1 && g == gap) begin
            #2;
            chk("lit_mono_valid", oSampleValid, 1);
            chk("lit_mono_sample", oSample, 16'h0001);
            chk("lit_mono_index", oSampleIndex, 16'd0);
          end
          if (pin == 2 && c == 1 && i == 0 && g == 0) begin
            #2;
            chk("lit_reloc", oRamReadAddr, 16'h010A);
          end
          if (abort && c == 1 && i == 2 && g == gap) begin
            @(posedge iClock);
            #1;
            iReset = 1'b0;
            iDecSampleValid = 1'b0;
            m_phase = P_IDLE;
            m_base = 16'd0;
            m_bs = 16'd0;
            m_err = 1'b0;
            #1;
            chk("lit_async_busy", oBusy, 0);
            chk("lit_async_dec_reset", oDecReset, 1);
            repeat (2) @(posedge iClock);
            #1;
            iReset = 1'b1;
            return;
          end
        end
      end
      cyc(P_NEXT, 0, 16'd0, 16'hFFFF, 0, 3'(c), 16'd0);
      prev_max = chmax;
    end
    cyc(P_FIN, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
    m_base = 16'(m_base + prev_max + 16'd1);
    cyc(P_IDLE, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
  endtask

  initial begin
    repeat (3) @(posedge iClock);
    #1;
    iReset = 1'b1;
    repeat (2) cyc(P_IDLE, 0, 16'd0, 16'd7, 0, 3'd0, 16'd0);

    // mono frame, samples 1..4
    run_frame(16'h0040, 16'd3, 3'd0, 0, 1, 0, 0);
    // stereo relocation, channel 0 tops out at address 9
    run_frame(16'h0100, 16'd7, 3'd1, 1, 2, 0, 0);
    cyc(P_IDLE, 0, 16'd0, 16'h0003, 0, 3'd0, 16'd0);
    #2;
    chk("lit_final_base", oRamReadAddr, 16'h0117);
    // iStart and changed frame inputs while running must be ignored
    run_frame(16'h1000, 16'd2, 3'd2, 1, 0, 1, 0);
    // address wrap past 0xFFFF
    run_frame(16'hFFFC, 16'd1, 3'd1, 0, 0, 0, 0);
    // all eight channels, one sample each
    run_frame(16'h2000, 16'd0, 3'd7, 0, 0, 0, 0);
    // reset in the middle of channel 1, then a clean frame
    run_frame(16'h0200, 16'd5, 3'd1, 0, 0, 0, 1);
    repeat (3) cyc(P_IDLE, 0, 16'd0, 16'd4, 0, 3'd0, 16'd0);
    run_frame(16'h0040, 16'd3, 3'd0, 0, 0, 0, 0);
    // strobes arriving exactly WDOG cycles into a stall
    run_frame(16'h0300, 16'd1, 3'd0, WDOG - 1, 0, 0, 0);

`ifdef SUBFRAME_SEQ_WATCHDOG_EN
    iBlockSize = 16'd3;
    iChannels = 3'd0;
    iFrameBase = 16'h0400;
    cyc(P_IDLE, 0, 16'd0, 16'd0, 1, 3'd0, 16'd0);
    cyc(P_RST, 0, 16'd0, 16'hFFFF, 0, 3'd0, 16'd0);
    m_base = 16'h0400;
    m_bs = 16'd3;
    m_err = 1'b0;
    cyc(P_RUN, 1, 16'h0AAA, 16'd1, 0, 3'd0, 16'd0);
    cyc(P_RUN, 1, 16'h0BBB, 16'd2, 0, 3'd0, 16'd1);
    for (int g = 0; g < WDOG - 1; g++) cyc(P_RUN, 0, 16'd0, 16'(g), 0, 3'd0, 16'd0);
    cyc(P_EXP, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
    m_err = 1'b1;
    #2;
    chk("lit_wdog_error", oError, 1);
    cyc(P_FIN, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
    repeat (3) cyc(P_IDLE, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
    run_frame(16'h0040, 16'd3, 3'd0, 0, 0, 0, 0);
`endif

    repeat (2) cyc(P_IDLE, 0, 16'd0, 16'd0, 0, 3'd0, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
